dev_link_rx: RTL and testbench

- Far end of the device command link: 8N1 UART receiver plus command-frame decoder.
- Deserialises the byte sent by the simulated device, which is {2'b10, destroy_beacon, place_beacon, moving_state[3:0]}.
- Checks the 2'b10 header, then presents the moving state, beacon events and link health to the simulator-side logic.
- Sits beside the detector-status transmitter on the same serial pair, at the opposite end from the device.

---
 rtl/dev_link_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 33 +++
 rtl/dev_link_rx.sv | 173 +++++++++++++++++
 tb/tb_dev_link_rx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dev_link_pkg.sv
// Shared types and constants for the device command link receiver.
// Pure definitions: no latency, no flow control.
package dev_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  localparam logic [1:0] FRAME_HDR = 2'b10;

  localparam int MOV_LSB = 0;
  localparam int PL_BIT  = 4;
  localparam int DE_BIT  = 5;
  localparam int HDR_MSB = 7;

  function automatic int calc_div(input int clk_freq, input int baud, input int ovs);
    return clk_freq / (baud * ovs);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every DIV clocks, phase reset by restart.
// Tick is registered (1 cycle after the count wraps); no backpressure, free-running.
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/dev_link_rx.sv
// 8N1 receiver + command-frame decoder; outputs register 1 cycle after the stop-bit sample.
// No backpressure: event pulses are fire-and-forget. DEV_LINK_RX_TIMEOUT_EN builds the link-loss timer.
module dev_link_rx
  import dev_link_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int OVS      = 16
`ifdef DEV_LINK_RX_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 10_000_000
`endif
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       rx,
  output logic [3:0] moving_state,
  output logic       place_pulse,
  output logic       destroy_pulse,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       hdr_err,
  output logic [7:0] rx_byte,
  output logic       link_ok
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVS);
  localparam int TW  = $clog2(OVS);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVS - 1);

`ifdef DEV_LINK_RX_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TOW-1:0] TO_MAX = TOW'(TIMEOUT_CYCLES);
  localparam logic [TOW-1:0] TO_PRE = TOW'(TIMEOUT_CYCLES - 1);
  logic [TOW-1:0] to_cnt;
`endif

  rx_state_t     state;
  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          pl_hist;
  logic          de_hist;
  logic          tick;
  logic          fall;
  logic          restart;

  assign fall    = rx_prev & ~rx_sync;
  assign restart = (state == ST_IDLE) && fall;

  uart_baud_tick #(
    .DIV(DIV)
  ) u_tick (
    .sys_clk(sys_clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      rx_meta       <= 1'b1;
      rx_sync       <= 1'b1;
      rx_prev       <= 1'b1;
      state         <= ST_IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      pl_hist       <= 1'b0;
      de_hist       <= 1'b0;
      moving_state  <= '0;
      place_pulse   <= 1'b0;
      destroy_pulse <= 1'b0;
      frame_valid   <= 1'b0;
      frame_err     <= 1'b0;
      hdr_err       <= 1'b0;
      rx_byte       <= '0;
      link_ok       <= 1'b0;
`ifdef DEV_LINK_RX_TIMEOUT_EN
      to_cnt        <= '0;
`endif
    end else begin
      rx_meta       <= rx;
      rx_sync       <= rx_meta;
      rx_prev       <= rx_sync;
      place_pulse   <= 1'b0;
      destroy_pulse <= 1'b0;
      frame_valid   <= 1'b0;
      frame_err     <= 1'b0;
      hdr_err       <= 1'b0;

`ifdef DEV_LINK_RX_TIMEOUT_EN
      // Loss stops the vehicle; a valid frame below overrides in the same cycle.
      if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
      if (to_cnt == TO_PRE) begin
        link_ok      <= 1'b0;
        moving_state <= '0;
      end
`endif

      case (state)
        ST_IDLE: begin
          if (fall) begin
            state    <= ST_START;
            tick_cnt <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rx_sync ? ST_IDLE : ST_DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              shreg    <= {rx_sync, shreg[7:1]};
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) state <= ST_STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              if (rx_sync) begin
                state   <= ST_IDLE;
                rx_byte <= shreg;
                if (shreg[HDR_MSB -: 2] == FRAME_HDR) begin
                  frame_valid   <= 1'b1;
                  moving_state  <= shreg[MOV_LSB +: 4];
                  place_pulse   <= shreg[PL_BIT] & ~pl_hist;
                  destroy_pulse <= shreg[DE_BIT] & ~de_hist;
                  pl_hist       <= shreg[PL_BIT];
                  de_hist       <= shreg[DE_BIT];
                  link_ok       <= 1'b1;
`ifdef DEV_LINK_RX_TIMEOUT_EN
                  to_cnt        <= '0;
`endif
                end else begin
                  hdr_err <= 1'b1;
                end
              end else begin
                frame_err <= 1'b1;
                state     <= ST_BREAK;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        ST_BREAK: begin
          if (tick && rx_sync) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dev_link_rx.sv
// Scoreboard bench for dev_link_rx: expected frame events queued at send time, checked on DUT pulses.
// Runs with a fast line (DIV = 2) so every frame fits in a few hundred cycles.
module tb_dev_link_rx;

  localparam int CLK_FREQ = 320_000;
  localparam int BAUD     = 10_000;
  localparam int OVS      = 16;
  localparam int BIT      = OVS * (CLK_FREQ / (BAUD * OVS));
  localparam int TO       = 1000;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [3:0] moving_state;
  logic       place_pulse;
  logic       destroy_pulse;
  logic       frame_valid;
  logic       frame_err;
  logic       hdr_err;
  logic [7:0] rx_byte;
  logic       link_ok;

  dev_link_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD),
    .OVS     (OVS)
`ifdef DEV_LINK_RX_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .rx           (rx),
    .moving_state (moving_state),
    .place_pulse  (place_pulse),
    .destroy_pulse(destroy_pulse),
    .frame_valid  (frame_valid),
    .frame_err    (frame_err),
    .hdr_err      (hdr_err),
    .rx_byte      (rx_byte),
    .link_ok      (link_ok)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [2:0] ev;   // {frame_valid, hdr_err, frame_err}
    logic [7:0] byte_v;
    logic [3:0] ms;
    logic       pl;
    logic       de;
    logic       lk;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_fv = 0;

  // reference model state
  logic [3:0] m_ms;
  logic [7:0] m_byte;
  logic       m_pl, m_de, m_link;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ms = '0; m_byte = '0; m_pl = 1'b0; m_de = 1'b0; m_link = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    exp_t e;
    e.pl = 1'b0;
    e.de = 1'b0;
    if (!stop) begin
      e.ev = 3'b001;
    end else if (b[7:6] == 2'b10) begin
      e.ev = 3'b100;
      e.pl = b[4] & ~m_pl;
      e.de = b[5] & ~m_de;
      m_pl = b[4];
      m_de = b[5];
      m_ms = b[3:0];
      m_link = 1'b1;
      m_byte = b;
    end else begin
      e.ev = 3'b010;
      m_byte = b;
    end
    e.byte_v = m_byte;
    e.ms = m_ms;
    e.lk = m_link;
    q.push_back(e);
    @(negedge sys_clk) rx = 1'b0;
    repeat (BIT) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge sys_clk);
    end
    rx = stop;
    repeat (BIT) @(negedge sys_clk);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge sys_clk);
  endtask

  task automatic wait_drained();
    for (int i = 0; i < 5000 && q.size() != 0; i++) @(negedge sys_clk);
    chk("queue_drained", q.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {moving_state, place_pulse, destroy_pulse, frame_valid, frame_err, hdr_err, rx_byte, link_ok}, 0);
  endtask

  always @(posedge sys_clk) cyc <= cyc + 1;

  // monitor: every event pulse must match the oldest queued expectation
  logic [4:0] prev_pls = '0;
  exp_t       mon_e;
  always @(negedge sys_clk) begin
    logic [4:0] pls;
    logic [2:0] ev;
    pls = {frame_valid, hdr_err, frame_err, place_pulse, destroy_pulse};
    ev  = {frame_valid, hdr_err, frame_err};
    if (!rst) begin
      prev_pls = '0;
    end else begin
      if (|pls) chk("pulse_width", pls & prev_pls, 0);
      prev_pls = pls;
      if (ev != 3'b000) begin
        if (q.size() == 0) begin
          chk("unexpected_event", ev, 0);
        end else begin
          mon_e = q.pop_front();
          chk("event_kind", ev, mon_e.ev);
          chk("rx_byte", rx_byte, mon_e.byte_v);
          chk("moving_state", moving_state, mon_e.ms);
          chk("place_pulse", place_pulse, mon_e.pl);
          chk("destroy_pulse", destroy_pulse, mon_e.de);
          chk("link_ok", link_ok, mon_e.lk);
          if (frame_valid) last_fv = cyc;
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge sys_clk);
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    rx  = 1'b1;
    model_reset();
    repeat (5) @(negedge sys_clk);
    chk_all_zero("reset_outputs");
    rst = 1'b1;
    repeat (BIT) @(negedge sys_clk);

    send_frame(8'h85, 1'b1);
    send_frame(8'h95, 1'b1);
    send_frame(8'h95, 1'b1);
    send_frame(8'h85, 1'b1);
    send_frame(8'h95, 1'b1);
    send_frame(8'h85, 1'b1);
    send_frame(8'hB3, 1'b1);
    send_frame(8'h45, 1'b1);
    send_frame(8'h85, 1'b0);
    wait_drained();
    chk("rx_byte_after_ferr", rx_byte, 8'h45);

    // short low glitch on idle line must be rejected
    @(negedge sys_clk) rx = 1'b0;
    repeat (6) @(negedge sys_clk);
    rx = 1'b1;
    repeat (4 * BIT) @(negedge sys_clk);

    // reset in the middle of a byte
    rx = 1'b0;
    repeat (BIT) @(negedge sys_clk);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 0 || i == 2);
      repeat (BIT) @(negedge sys_clk);
    end
    rst = 1'b0;
    rx  = 1'b1;
    model_reset();
    repeat (10) @(negedge sys_clk);
    chk_all_zero("midbyte_reset_outputs");
    rst = 1'b1;
    repeat (BIT) @(negedge sys_clk);
    chk_all_zero("post_reset_idle");

    send_frame(8'h8A, 1'b1);
    wait_drained();
    chk("ms_after_8a", moving_state, 4'b1010);

    // link timeout behaviour
    send_frame(8'h8F, 1'b1);
    wait_drained();
    while (cyc < last_fv + TO - 1) @(negedge sys_clk);
    chk("link_ok_before_to", link_ok, 1'b1);
    chk("ms_before_to", moving_state, 4'hF);
    @(negedge sys_clk);
`ifdef DEV_LINK_RX_TIMEOUT_EN
    chk("link_ok_at_to", link_ok, 1'b0);
    chk("ms_at_to", moving_state, 4'h0);
    m_ms = 4'h0;
    m_link = 1'b0;
`else
    chk("link_ok_held", link_ok, 1'b1);
    chk("ms_held", moving_state, 4'hF);
`endif
    repeat (200) @(negedge sys_clk);
    chk("link_ok_later", link_ok, m_link);
    chk("ms_later", moving_state, m_ms);

    send_frame(8'h95, 1'b1);
    wait_drained();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
